// File: rtl/int_ctrl.sv
// Interrupt sequencer: latches request edges, drains the pipeline, redirects the PC
// to a per-source vector and returns to the saved PC on mret.
module int_ctrl #(
    parameter int unsigned N_IRQ        = 4,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
    parameter int unsigned VEC_SHIFT    = 4,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             int_en,
    input  logic [31:0]      resume_pc,
    input  logic             mret,
    output logic             int_set_pl_pause,
    output logic             int_flag,
    output logic [31:0]      nextpc_int,
    output logic [31:0]      epc,
    output logic [2:0]       cause,
    output logic             in_handler,
    output logic [N_IRQ-1:0] pending
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CAUSE_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_JUMP,
        S_HANDLER,
        S_RET
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [N_IRQ-1:0]     irq_q;
    logic [N_IRQ-1:0]     rise;
    logic [N_IRQ-1:0]     clear;
    logic [N_IRQ-1:0]     req;
    logic [N_IRQ-1:0]     pending_d;
    logic [CAUSE_W-1:0]   sel;
    logic [CAUSE_W-1:0]   cause_d;
    logic [31:0]          epc_d;
    logic                 pause_d;
    logic                 flag_d;
    logic [31:0]          nextpc_d;
    logic                 in_handler_d;

    // Edge detect and pending bookkeeping; a new edge beats the JUMP-cycle clear.
    always_comb begin
        rise  = irq & ~irq_q;
        clear = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            clear[i] = (state_q == S_JUMP) && (cause == CAUSE_W'(i));
        end
        pending_d = (pending & ~clear) | rise;
    end

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        req = pending & irq_mask;
        sel = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = CAUSE_W'(i);
            end
        end
    end

    // Next-state logic plus decode of the registered outputs from the next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cause_d      = cause;
        epc_d        = epc;
        pause_d      = 1'b0;
        flag_d       = 1'b0;
        nextpc_d     = '0;
        in_handler_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (int_en && (|req)) begin
                    state_d = S_PAUSE;
                    cnt_d   = CNT_W'(1);
                    cause_d = sel;
                end
            end
            S_PAUSE: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES)) begin
                    state_d = S_JUMP;
                    cnt_d   = '0;
                    epc_d   = resume_pc;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_JUMP: begin
                state_d = S_HANDLER;
            end
            S_HANDLER: begin
                if (mret) begin
                    state_d = S_RET;
                end
            end
            S_RET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        unique case (state_d)
            S_PAUSE: begin
                pause_d = 1'b1;
            end
            S_JUMP: begin
                flag_d       = 1'b1;
                nextpc_d     = VEC_BASE + (32'(cause_d) << VEC_SHIFT);
                in_handler_d = 1'b1;
            end
            S_HANDLER: begin
                in_handler_d = 1'b1;
            end
            S_RET: begin
                flag_d       = 1'b1;
                nextpc_d     = epc_d;
                in_handler_d = 1'b1;
            end
            default: begin
                pause_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            irq_q            <= '0;
            pending          <= '0;
            epc              <= '0;
            cause            <= '0;
            int_set_pl_pause <= 1'b0;
            int_flag         <= 1'b0;
            nextpc_int       <= '0;
            in_handler       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            irq_q            <= irq;
            pending          <= pending_d;
            epc              <= epc_d;
            cause            <= cause_d;
            int_set_pl_pause <= pause_d;
            int_flag         <= flag_d;
            nextpc_int       <= nextpc_d;
            in_handler       <= in_handler_d;
        end
    end

    // Pause and redirect are mutually exclusive; cause always names a real source.
    a_pause_flag_excl: assert property (@(posedge clk) disable iff (!clr_n)
        !(int_set_pl_pause && int_flag));
    a_cause_range: assert property (@(posedge clk) disable iff (!clr_n)
        32'(cause) < N_IRQ);

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a timeline model of the interrupt sequence.
module tb_int_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned D  = 3;
    localparam logic [31:0] VB = 32'h0000_0100;
    localparam int unsigned SH = 4;

    logic          clk = 1'b0;
    logic          clr_n;
    logic [N-1:0]  irq;
    logic [N-1:0]  irq_mask;
    logic          int_en;
    logic [31:0]   resume_pc;
    logic          mret;
    logic          int_set_pl_pause;
    logic          int_flag;
    logic [31:0]   nextpc_int;
    logic [31:0]   epc;
    logic [2:0]    cause;
    logic          in_handler;
    logic [N-1:0]  pending;

    int total = 0;
    int bad   = 0;

    int_ctrl #(
        .N_IRQ(N), .VEC_BASE(VB), .VEC_SHIFT(SH), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .clr_n(clr_n), .irq(irq), .irq_mask(irq_mask), .int_en(int_en),
        .resume_pc(resume_pc), .mret(mret), .int_set_pl_pause(int_set_pl_pause),
        .int_flag(int_flag), .nextpc_int(nextpc_int), .epc(epc), .cause(cause),
        .in_handler(in_handler), .pending(pending)
    );

    always #5 clk = ~clk;

    // Timeline model: a service that starts at cycle m_start spends D cycles
    // paused, one cycle jumping, then sits in the handler until mret.
    int           cyc;
    logic         m_busy;
    int           m_start;
    int           m_ret_at;
    logic [2:0]   m_cause;
    logic [31:0]  m_epc;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_irq_prev;

    task automatic model_reset();
        cyc = 0; m_busy = 1'b0; m_start = 0; m_ret_at = -1;
        m_cause = '0; m_epc = '0; m_pend = '0; m_irq_prev = '0;
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        logic         prev_jump, prev_handler, prev_ret;
        logic [N-1:0] pend_old, rise;
        cyc++;
        prev_jump    = m_busy && (cyc - 1 - m_start == int'(D));
        prev_handler = m_busy && (cyc - 1 - m_start > int'(D)) && (m_ret_at < 0);
        prev_ret     = m_busy && (m_ret_at == cyc - 1);
        pend_old     = m_pend;
        rise         = irq & ~m_irq_prev;
        m_irq_prev   = irq;
        if (!m_busy) begin
            if (int_en && |(pend_old & irq_mask)) begin
                m_busy = 1'b1; m_start = cyc; m_ret_at = -1;
                m_cause = 3'(lowest(pend_old & irq_mask));
            end
        end else if (prev_ret) begin
            m_busy = 1'b0;
        end else begin
            if (cyc - m_start == int'(D)) m_epc = resume_pc;
            if (prev_handler && mret) m_ret_at = cyc;
        end
        if (prev_jump) pend_old[m_cause] = 1'b0;
        m_pend = pend_old | rise;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        logic        e_pause, e_flag, e_inh;
        logic [31:0] e_pc;
        int          k;
        e_pause = 1'b0; e_flag = 1'b0; e_inh = 1'b0; e_pc = '0;
        if (m_busy) begin
            k = cyc - m_start;
            if (k < int'(D)) e_pause = 1'b1;
            else if (k == int'(D)) begin
                e_flag = 1'b1; e_inh = 1'b1; e_pc = VB + (32'(m_cause) << SH);
            end else if (m_ret_at == cyc) begin
                e_flag = 1'b1; e_inh = 1'b1; e_pc = m_epc;
            end else e_inh = 1'b1;
        end
        chk("pause", 32'(int_set_pl_pause), 32'(e_pause));
        chk("flag", 32'(int_flag), 32'(e_flag));
        chk("nextpc", nextpc_int, e_pc);
        chk("in_handler", 32'(in_handler), 32'(e_inh));
        chk("epc", epc, m_epc);
        chk("cause", 32'(cause), 32'(m_cause));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (clr_n) model_step(); else model_reset();
        @(negedge clk);
        compare();
    endtask

    task automatic reset_now(input string tag);
        clr_n = 1'b0;
        #1;
        chk({tag, "_rst_pause"}, 32'(int_set_pl_pause), 32'd0);
        chk({tag, "_rst_flag"}, 32'(int_flag), 32'd0);
        chk({tag, "_rst_nextpc"}, nextpc_int, 32'd0);
        chk({tag, "_rst_inh"}, 32'(in_handler), 32'd0);
        chk({tag, "_rst_pend"}, 32'(pending), 32'd0);
        chk({tag, "_rst_epc"}, epc, 32'd0);
        chk({tag, "_rst_cause"}, 32'(cause), 32'd0);
        model_reset();
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    task automatic run_until_flag(input string tag, output int pauses);
        logic got;
        got = 1'b0;
        pauses = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (int_set_pl_pause) pauses++;
            if (int_flag) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s: no int_flag within 40 cycles (got 0 want 1)", tag);
        end
    endtask

    task automatic finish_handler();
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
    endtask

    initial begin
        int p;
        int flags;
        clr_n = 1'b0; irq = '0; irq_mask = '1; int_en = 1'b1;
        resume_pc = '0; mret = 1'b0;
        model_reset();
        @(negedge clk);
        reset_now("init");

        // Single source: three pause cycles, then vector 2.
        irq = 4'b0100; resume_pc = 32'h40;
        tick();
        chk("t1_pend_set", 32'(pending), 32'h4);
        run_until_flag("t1", p);
        chk("t1_pauses", 32'(p), 32'd3);
        chk("t1_vec", nextpc_int, 32'h120);
        chk("t1_cause", 32'(cause), 32'd2);
        chk("t1_epc", epc, 32'h40);
        tick();
        chk("t1_pend_clr", 32'(pending[2]), 32'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t1_ret_pc", nextpc_int, 32'h40);
        chk("t1_ret_flag", 32'(int_flag), 32'd1);
        tick();

        // Simultaneous edges: source 1 before source 3, one idle cycle between.
        irq = 4'b1010; resume_pc = 32'h80;
        tick();
        run_until_flag("t2a", p);
        chk("t2_vec1", nextpc_int, 32'h110);
        tick();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("t2_ret_pc", nextpc_int, 32'h80);
        tick();
        chk("t2_idle_gap", 32'(int_set_pl_pause), 32'd0);
        tick();
        chk("t2_restart", 32'(int_set_pl_pause), 32'd1);
        run_until_flag("t2b", p);
        chk("t2_vec3", nextpc_int, 32'h130);
        finish_handler();

        // Masked source latches but waits for its enable.
        irq = '0;
        tick();
        irq_mask = 4'b1110; irq = 4'b0001;
        tick();
        chk("t3_pend", 32'(pending), 32'h1);
        tick();
        tick();
        chk("t3_masked", 32'(int_set_pl_pause), 32'd0);
        irq_mask = 4'hF;
        tick();
        chk("t3_go", 32'(int_set_pl_pause), 32'd1);
        run_until_flag("t3", p);
        chk("t3_vec0", nextpc_int, 32'h100);
        finish_handler();

        // Global disable holds off service; held-high irq[0] does not re-pend.
        int_en = 1'b0; irq = 4'b1001;
        tick(); tick(); tick();
        chk("t4_hold_pause", 32'(int_set_pl_pause), 32'd0);
        chk("t4_edge_only", 32'(pending), 32'h8);
        int_en = 1'b1;
        tick();
        chk("t4_go", 32'(int_set_pl_pause), 32'd1);
        run_until_flag("t4", p);
        chk("t4_vec3", nextpc_int, 32'h130);

        // Edge during handler waits for return plus one idle cycle.
        tick();
        irq = 4'b1011;
        tick(); tick();
        chk("t5_no_nest", 32'(int_set_pl_pause), 32'd0);
        chk("t5_pend", 32'(pending), 32'h2);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        tick();
        chk("t5_gap", 32'(int_set_pl_pause), 32'd0);
        tick();
        chk("t5_restart", 32'(int_set_pl_pause), 32'd1);
        run_until_flag("t5", p);
        chk("t5_vec1", nextpc_int, 32'h110);
        finish_handler();

        // Reset mid-pause aborts the sequence without any redirect.
        irq = '0;
        tick();
        irq = 4'b0100;
        tick(); tick();
        chk("t6_in_pause", 32'(int_set_pl_pause), 32'd1);
        irq = '0;
        reset_now("t6");
        flags = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int_flag) flags++;
        end
        chk("t6_no_flag", 32'(flags), 32'd0);
        chk("t6_pend", 32'(pending), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) irq = irq ^ N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 19) == 0) irq_mask = N'($urandom);
            int_en    = ($urandom_range(0, 9) != 0);
            resume_pc = $urandom;
            mret      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 799) == 0) begin
                mret = 1'b0;
                reset_now("rnd");
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt sequencer directly upstream of the pipeline status controller and the PC register.
- Latches external interrupt request edges and picks the highest-priority enabled source.
- Drives `int_set_pl_pause` to drain the pipeline, then `int_flag` together with `nextpc_int` to redirect the PC to a per-source vector.
- Saves the resume PC and, on `mret`, redirects back through the same `int_flag`/`nextpc_int` path.

Parameters:
- N_IRQ, 4, number of interrupt request lines (1..8).
- VEC_BASE, 32'h0000_0100, address of the source-0 handler.
- VEC_SHIFT, 4, vector spacing: vector = VEC_BASE + (idx << VEC_SHIFT).
- DRAIN_CYCLES, 3, number of cycles `int_set_pl_pause` is held before the jump (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr_n  in  1  asynchronous active-low reset.
- irq  in  N_IRQ  level request lines; rising edge sets pending.
- irq_mask  in  N_IRQ  per-source enable, 1 = enabled.
- int_en  in  1  global interrupt enable.
- resume_pc  in  32  PC of the oldest uncommitted instruction, from the datapath.
- mret  in  1  one-cycle pulse when the handler return instruction commits.
- int_set_pl_pause  out  1  freeze all pipeline stages.
- int_flag  out  1  flush the pipeline and load `nextpc_int`.
- nextpc_int  out  32  redirect target.
- epc  out  32  saved resume PC.
- cause  out  3  index of the source being serviced.
- in_handler  out  1  high from JUMP through RET inclusive.
- pending  out  N_IRQ  latched pending bits.

Behaviour:
- Reset is asynchronous, active-low. While `clr_n` = 0:
  - state = IDLE, counter = 0.
  - `pending`, `irq` delay register, `epc`, `cause` = 0.
  - All outputs = 0.
  - Reset asserted in any state aborts the sequence; no return redirect is issued.
- Edge detect: `irq_q` <= `irq` every cycle; `rise = irq & ~irq_q`.
- Pending update: `pending` <= (`pending` & ~`clear`) | `rise`.
  - `clear` is a one-hot of `cause`, applied only in the JUMP cycle.
  - Set wins over clear on the same bit in the same cycle.
- Selection: `sel` = lowest index i with `pending[i]` & `irq_mask[i]`. Index 0 has the highest priority.
- Outputs are registered Moore decodes of the state.
- IDLE:
  - If `int_en` & |(`pending` & `irq_mask`): go to PAUSE, `counter` <= 1, `cause` <= `sel`.
  - Otherwise stay in IDLE.
  - `mret` is ignored in IDLE.
- PAUSE:
  - `int_set_pl_pause` = 1.
  - When `counter` == DRAIN_CYCLES: `epc` <= `resume_pc`, go to JUMP.
  - Otherwise `counter` <= `counter` + 1.
  - Exactly DRAIN_CYCLES pause cycles occur.
  - Deasserting `int_en` or `irq_mask` during PAUSE does not abort; the selected `cause` is serviced.
- JUMP (1 cycle):
  - `int_flag` = 1.
  - `nextpc_int` = VEC_BASE + (`cause` << VEC_SHIFT), 32-bit wrap.
  - Pending bit `cause` is cleared.
  - Next state: HANDLER.
- HANDLER:
  - `in_handler` = 1.
  - New edges set `pending` but never preempt (no nesting).
  - On `mret` = 1: go to RET.
- RET (1 cycle):
  - `int_flag` = 1, `nextpc_int` = `epc`.
  - Next state: IDLE.
  - A still-pending enabled source is taken at the earliest on the cycle after returning to IDLE, i.e. one instruction-fetch opportunity minimum.
- `nextpc_int` = 0 in all states except JUMP and RET.
- `int_set_pl_pause` and `int_flag` are never asserted in the same cycle.
- `epc` and `cause` hold their values until overwritten by the next entry into PAUSE/JUMP.
- Any `cause` >= N_IRQ is unreachable. The `cause` width is fixed at 3 bits, upper bits 0.

Test Plan:
1. Reset then `irq[2]` rises, `irq_mask` = 4'hF, `int_en` = 1, `resume_pc` = 32'h40 -> PAUSE high for 3 cycles; then `int_flag` for 1 cycle with `nextpc_int` = 32'h120; `cause` = 2; `epc` = 32'h40; `pending[2]` cleared.
2. `irq[3]` and `irq[1]` rise in the same cycle -> source 1 serviced first (`nextpc_int` = 32'h110). After `mret`: RET cycle with `nextpc_int` = `epc`. Source 3 then taken, `nextpc_int` = 32'h130.
3. `irq[0]` rises with `irq_mask[0]` = 0 -> `pending[0]` = 1, no pause. Set `irq_mask[0]` = 1 -> PAUSE begins the next cycle.
4. `int_en` = 0 with a pending enabled source -> stays IDLE, outputs 0. `int_en` -> 1 starts the sequence. Held-high `irq` produces no second pending after clear (edge-only).
5. `irq[1]` rises during HANDLER -> no pause until after RET; exactly one IDLE cycle passes before PAUSE restarts.
6. `clr_n` pulsed low mid-PAUSE -> all outputs 0 immediately (asynchronous). No JUMP or RET is issued after release; `pending` = 0.
